// File: rtl/face_pkg.sv
// Shared definitions for the face-tracking pipeline: FSM states, default
// chroma skin box and a width helper for sizing per-frame counters.
package face_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    END    = 2'd2
  } state_e;

  localparam int CB_MIN_DEF = 77;
  localparam int CB_MAX_DEF = 127;
  localparam int CR_MIN_DEF = 133;
  localparam int CR_MAX_DEF = 173;

  // Ceiling log2; a counter that must hold the value N needs clog2(N+1) bits.
  function automatic int clog2(input longint unsigned value);
    int bits;
    longint unsigned v;
    bits = 0;
    if (value > 1) begin
      v = value - 1;
      while (v > 0) begin
        bits++;
        v = v >> 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/skin_classifier.sv
// Combinational chroma box test: a pixel is skin when both Cb and Cr fall
// inside their inclusive unsigned bounds.
module skin_classifier #(
  parameter int DATA_WIDTH = 8,
  parameter int CB_MIN     = 77,
  parameter int CB_MAX     = 127,
  parameter int CR_MIN     = 133,
  parameter int CR_MAX     = 173
) (
  input  logic [DATA_WIDTH-1:0] cb_i,
  input  logic [DATA_WIDTH-1:0] cr_i,
  output logic                  skin_o
);

  localparam logic [DATA_WIDTH-1:0] CbLo = DATA_WIDTH'(CB_MIN);
  localparam logic [DATA_WIDTH-1:0] CbHi = DATA_WIDTH'(CB_MAX);
  localparam logic [DATA_WIDTH-1:0] CrLo = DATA_WIDTH'(CR_MIN);
  localparam logic [DATA_WIDTH-1:0] CrHi = DATA_WIDTH'(CR_MAX);

  // Both channels must sit inside the box; bounds are inclusive.
  always_comb begin
    skin_o = (cb_i >= CbLo) && (cb_i <= CbHi) && (cr_i >= CrLo) && (cr_i <= CrHi);
  end

endmodule

// File: rtl/skin_coord_gen.sv
// Raster tracker feeding the centroid stage: classifies each pixel, emits the
// (x,y) of skin pixels one cycle later, and closes every frame with a single
// coord_end pulse (plus frame_abort when a new sof cut the frame short).
module skin_coord_gen
  import face_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int IMG_WIDTH   = 256,
  parameter int IMG_HEIGHT  = 256,
  parameter int CB_MIN      = CB_MIN_DEF,
  parameter int CB_MAX      = CB_MAX_DEF,
  parameter int CR_MIN      = CR_MIN_DEF,
  parameter int CR_MAX      = CR_MAX_DEF,
  parameter int COUNT_WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  pix_cb,
  input  logic [DATA_WIDTH-1:0]  pix_cr,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  output logic [DATA_WIDTH-1:0]  coord_x,
  output logic [DATA_WIDTH-1:0]  coord_y,
  output logic                   coord_enable,
  output logic                   coord_end,
  output logic [COUNT_WIDTH-1:0] skin_count,
  output logic                   frame_abort
);

  localparam logic [DATA_WIDTH-1:0]  XLast   = DATA_WIDTH'(IMG_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0]  YLast   = DATA_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [COUNT_WIDTH-1:0] CntMax  = {COUNT_WIDTH{1'b1}};

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  xPos_q, xPos_d;
  logic [DATA_WIDTH-1:0]  yPos_q, yPos_d;
  logic [COUNT_WIDTH-1:0] frameCnt_q, frameCnt_d;
  logic                   abortEnd_q, abortEnd_d;
  logic [DATA_WIDTH-1:0]  coordX_q, coordX_d;
  logic [DATA_WIDTH-1:0]  coordY_q, coordY_d;
  logic                   coordEn_q, coordEn_d;
  logic                   coordEnd_q, coordEnd_d;
  logic [COUNT_WIDTH-1:0] skinCnt_q, skinCnt_d;
  logic                   frameAbort_q, frameAbort_d;

  logic                   pixSkin;
  logic                   take;
  logic [DATA_WIDTH-1:0]  pixX;
  logic [DATA_WIDTH-1:0]  pixY;
  logic [COUNT_WIDTH-1:0] cntBase;

  skin_classifier #(
    .DATA_WIDTH (DATA_WIDTH),
    .CB_MIN     (CB_MIN),
    .CB_MAX     (CB_MAX),
    .CR_MIN     (CR_MIN),
    .CR_MAX     (CR_MAX)
  ) uClassifier (
    .cb_i   (pix_cb),
    .cr_i   (pix_cr),
    .skin_o (pixSkin)
  );

  // Next-state and registered-output logic: decide whether this cycle's pixel
  // is taken, where it sits in the raster, and how the frame ends.
  always_comb begin
    state_d      = state_q;
    xPos_d       = xPos_q;
    yPos_d       = yPos_q;
    frameCnt_d   = frameCnt_q;
    abortEnd_d   = abortEnd_q;
    coordX_d     = coordX_q;
    coordY_d     = coordY_q;
    coordEn_d    = 1'b0;
    coordEnd_d   = 1'b0;
    skinCnt_d    = skinCnt_q;
    frameAbort_d = 1'b0;
    take         = 1'b0;
    pixX         = xPos_q;
    pixY         = yPos_q;
    cntBase      = frameCnt_q;

    case (state_q)
      IDLE: begin
        if (pix_valid && pix_sof) begin
          take    = 1'b1;
          pixX    = '0;
          pixY    = '0;
          cntBase = '0;
        end
      end
      ACTIVE: begin
        if (pix_valid) begin
          if (pix_sof) begin
            // A new frame started before this one finished: report the
            // abort right away and keep the previous skin_count.
            state_d      = END;
            abortEnd_d   = 1'b1;
            coordEnd_d   = 1'b1;
            frameAbort_d = 1'b1;
          end else begin
            take = 1'b1;
          end
        end
      end
      END: begin
        state_d    = IDLE;
        abortEnd_d = 1'b0;
        if (!abortEnd_q) begin
          coordEnd_d = 1'b1;
          skinCnt_d  = frameCnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      if (pixSkin) begin
        coordEn_d  = 1'b1;
        coordX_d   = pixX;
        coordY_d   = pixY;
        frameCnt_d = (cntBase == CntMax) ? cntBase : cntBase + COUNT_WIDTH'(1);
      end else begin
        frameCnt_d = cntBase;
      end

      if (pixX == XLast) begin
        xPos_d = '0;
        yPos_d = pixY + DATA_WIDTH'(1);
      end else begin
        xPos_d = pixX + DATA_WIDTH'(1);
        yPos_d = pixY;
      end

      if ((pixX == XLast) && (pixY == YLast)) begin
        state_d    = END;
        abortEnd_d = 1'b0;
      end else begin
        state_d = ACTIVE;
      end
    end
  end

  // State and output registers; reset drops everything to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      xPos_q       <= '0;
      yPos_q       <= '0;
      frameCnt_q   <= '0;
      abortEnd_q   <= 1'b0;
      coordX_q     <= '0;
      coordY_q     <= '0;
      coordEn_q    <= 1'b0;
      coordEnd_q   <= 1'b0;
      skinCnt_q    <= '0;
      frameAbort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      xPos_q       <= xPos_d;
      yPos_q       <= yPos_d;
      frameCnt_q   <= frameCnt_d;
      abortEnd_q   <= abortEnd_d;
      coordX_q     <= coordX_d;
      coordY_q     <= coordY_d;
      coordEn_q    <= coordEn_d;
      coordEnd_q   <= coordEnd_d;
      skinCnt_q    <= skinCnt_d;
      frameAbort_q <= frameAbort_d;
    end
  end

  assign coord_x      = coordX_q;
  assign coord_y      = coordY_q;
  assign coord_enable = coordEn_q;
  assign coord_end    = coordEnd_q;
  assign skin_count   = skinCnt_q;
  assign frame_abort  = frameAbort_q;

endmodule
